// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - arbiter sharing the GRF write port between the W stage (P) and the multi-cycle unit (M)
// Optional feature macro: GRF_WB_TRACE_EN (prints one line per committed non-$0 write)
module grf_wb_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  // pipeline W stage writeback
  input  logic          p_valid,
  output logic          p_ready,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_data,
  input  logic [31:0]   p_pc,
  // multi-cycle unit writeback (MDU / late load)
  input  logic          m_valid,
  output logic          m_ready,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  input  logic [31:0]   m_pc,
  // registered GRF write port
  output logic          grf_we,
  output logic [AW-1:0] grf_a3,
  output logic [DW-1:0] grf_wd3,
  output logic [31:0]   grf_pc,
  // debug: consecutive cycles M has been denied
  output logic [2:0]    starve_cnt
);

  // The denial counter is only 3 bits wide, so the limit must fit in it.
  generate
    if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
      $error("grf_wb_arbiter: STARVE_MAX must be in 1..7");
    end
  endgenerate

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  logic          force_m;
  logic          grant_p;
  logic          grant_m;
  logic          xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [31:0]   sel_pc;

  // Grant: P has fixed priority unless M has already lost STARVE_MAX cycles in a row.
  always_comb begin
    force_m = m_valid && (starve_cnt == SMAX);
    grant_p = 1'b0;
    grant_m = 1'b0;
    if (reset_n) begin
      if (force_m) begin
        grant_m = 1'b1;
      end else if (p_valid) begin
        grant_p = 1'b1;
      end else if (m_valid) begin
        grant_m = 1'b1;
      end
    end
    xfer = grant_p || grant_m;
  end

  assign p_ready = grant_p;
  assign m_ready = grant_m;

  // Select the winning port's payload for the output register.
  always_comb begin
    sel_addr = p_addr;
    sel_data = p_data;
    sel_pc   = p_pc;
    if (grant_m) begin
      sel_addr = m_addr;
      sel_data = m_data;
      sel_pc   = m_pc;
    end
  end

  // Output register: one write per cycle, $0 writes are consumed but never enabled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grf_we  <= 1'b0;
      grf_a3  <= '0;
      grf_wd3 <= '0;
      grf_pc  <= '0;
    end else if (xfer) begin
      grf_we  <= (sel_addr != '0);
      grf_a3  <= sel_addr;
      grf_wd3 <= sel_data;
      grf_pc  <= sel_pc;
    end else begin
      grf_we  <= 1'b0;
    end
  end

  // Denial counter: grows while M waits unserved, clears on M transfer or M idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt <= 3'd0;
    end else if (m_valid && !grant_m) begin
      if (starve_cnt != SMAX) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end else begin
      starve_cnt <= 3'd0;
    end
  end

`ifdef GRF_WB_TRACE_EN
  // Trace each write that will be committed to the GRF at this edge.
  always_ff @(posedge clk) begin
    if (reset_n && xfer && (sel_addr != '0)) begin
      $display("@%h: $%d <= %h", sel_pc, sel_addr, sel_data);
    end
  end
`else
`endif

  // Both ports can never be granted in the same cycle.
  assert property (@(posedge clk) disable iff (!reset_n) !(p_ready && m_ready))
    else $error("grf_wb_arbiter: double grant");

  // The denial counter never runs past its limit.
  assert property (@(posedge clk) disable iff (!reset_n) starve_cnt <= SMAX)
    else $error("grf_wb_arbiter: starve_cnt overflow");

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - self-checking bench for grf_wb_arbiter
module tb_grf_wb_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          p_valid, m_valid;
  logic          p_ready, m_ready;
  logic [AW-1:0] p_addr, m_addr;
  logic [DW-1:0] p_data, m_data;
  logic [31:0]   p_pc, m_pc;
  logic          grf_we;
  logic [AW-1:0] grf_a3;
  logic [DW-1:0] grf_wd3;
  logic [31:0]   grf_pc;
  logic [2:0]    starve_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data), .m_pc(m_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd3(grf_wd3), .grf_pc(grf_pc),
    .starve_cnt(starve_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    p_valid = 1'b1; p_addr = 5'd1; p_data = 32'h11; p_pc = 32'h100;
    m_valid = 1'b1; m_addr = 5'd2; m_data = 32'h22; m_pc = 32'h200;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (p_ready !== 1'b0) begin n_fail++; $display("FAIL reset_p_ready: got %b want 0", p_ready); end
      n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m_ready: got %b want 0", m_ready); end
      n_checks++; if (grf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", grf_we); end
      n_checks++; if (starve_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_starve: got %0d want 0", starve_cnt); end
    end
    n_checks++; if (grf_a3 !== 5'd0 || grf_wd3 !== 32'd0 || grf_pc !== 32'd0) begin
      n_fail++; $display("FAIL reset_regs: got a3=%0d wd3=%h pc=%h want zeros", grf_a3, grf_wd3, grf_pc);
    end
  endtask

  task automatic test_p_only();
    reset_n = 1'b1;
    m_valid = 1'b0;
    p_valid = 1'b1; p_addr = 5'd5; p_data = 32'hDEADBEEF; p_pc = 32'h3000;
    #1;
    n_checks++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL ponly_p_ready: got %b want 1", p_ready); end
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL ponly_m_ready: got %b want 0", m_ready); end
    tick();
    p_valid = 1'b0;
    n_checks++; if (grf_we !== 1'b1) begin n_fail++; $display("FAIL ponly_we: got %b want 1", grf_we); end
    n_checks++; if (grf_a3 !== 5'd5) begin n_fail++; $display("FAIL ponly_a3: got %0d want 5", grf_a3); end
    n_checks++; if (grf_wd3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ponly_wd3: got %h want deadbeef", grf_wd3); end
    n_checks++; if (grf_pc !== 32'h3000) begin n_fail++; $display("FAIL ponly_pc: got %h want 3000", grf_pc); end
    #1;
    n_checks++; if (p_ready !== 1'b0) begin n_fail++; $display("FAIL idle_p_ready: got %b want 0", p_ready); end
    tick();
    n_checks++; if (grf_we !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %b want 0", grf_we); end
    n_checks++; if (grf_a3 !== 5'd5 || grf_wd3 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL idle_hold: got a3=%0d wd3=%h want 5/deadbeef", grf_a3, grf_wd3);
    end
  endtask

  task automatic test_zero_drop();
    m_valid = 1'b1; m_addr = 5'd0; m_data = 32'h1234; m_pc = 32'h3008;
    #1;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL zero_m_ready: got %b want 1", m_ready); end
    n_checks++; if (p_ready !== 1'b0) begin n_fail++; $display("FAIL zero_p_ready: got %b want 0", p_ready); end
    tick();
    m_valid = 1'b0;
    n_checks++; if (grf_we !== 1'b0) begin n_fail++; $display("FAIL zero_we: got %b want 0", grf_we); end
    n_checks++; if (grf_a3 !== 5'd0 || grf_wd3 !== 32'h1234) begin
      n_fail++; $display("FAIL zero_regs: got a3=%0d wd3=%h want 0/1234", grf_a3, grf_wd3);
    end
    n_checks++; if (starve_cnt !== 3'd0) begin n_fail++; $display("FAIL zero_starve: got %0d want 0", starve_cnt); end
  endtask

  task automatic test_starvation();
    m_valid = 1'b1; m_addr = 5'd7; m_data = 32'hA5A5A5A5; m_pc = 32'h400C;
    p_valid = 1'b1; p_addr = 5'd2; p_pc = 32'h4000;
    for (int c = 0; c < SMAX; c++) begin
      p_data = 32'(c + 100);
      #1;
      n_checks++; if (p_ready !== 1'b1 || m_ready !== 1'b0) begin
        n_fail++; $display("FAIL starve_grant_p%0d: got p=%b m=%b want p=1 m=0", c, p_ready, m_ready);
      end
      tick();
      n_checks++; if (starve_cnt !== 3'(c + 1)) begin n_fail++; $display("FAIL starve_cnt%0d: got %0d want %0d", c, starve_cnt, c + 1); end
      n_checks++; if (grf_a3 !== 5'd2 || grf_wd3 !== 32'(c + 100)) begin
        n_fail++; $display("FAIL starve_pwrite%0d: got a3=%0d wd3=%h want 2/%h", c, grf_a3, grf_wd3, c + 100);
      end
    end
    p_data = 32'h0BADF00D;
    #1;
    n_checks++; if (m_ready !== 1'b1 || p_ready !== 1'b0) begin
      n_fail++; $display("FAIL starve_force: got p=%b m=%b want p=0 m=1", p_ready, m_ready);
    end
    tick();
    m_valid = 1'b0;
    n_checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd7 || grf_wd3 !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL starve_mwrite: got we=%b a3=%0d wd3=%h want 1/7/a5a5a5a5", grf_we, grf_a3, grf_wd3);
    end
    n_checks++; if (starve_cnt !== 3'd0) begin n_fail++; $display("FAIL starve_clear: got %0d want 0", starve_cnt); end
    #1;
    n_checks++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL starve_p_resume: got %b want 1", p_ready); end
    tick();
    p_valid = 1'b0;
    n_checks++; if (grf_a3 !== 5'd2 || grf_wd3 !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL starve_pheld: got a3=%0d wd3=%h want 2/0badf00d", grf_a3, grf_wd3);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    a[0] = 5'd4; a[1] = 5'd4; a[2] = 5'd6;
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
    p_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_addr = a[i]; p_data = d[i]; p_pc = 32'h6000 + 32'(4 * i);
      tick();
      n_checks++; if (grf_we !== 1'b1 || grf_a3 !== a[i] || grf_wd3 !== d[i]) begin
        n_fail++; $display("FAIL b2b_%0d: got we=%b a3=%0d wd3=%h want 1/%0d/%h", i, grf_we, grf_a3, grf_wd3, a[i], d[i]);
      end
    end
    p_valid = 1'b0;
    tick();
    n_checks++; if (grf_we !== 1'b0 || grf_a3 !== 5'd6) begin
      n_fail++; $display("FAIL b2b_idle: got we=%b a3=%0d want 0/6", grf_we, grf_a3);
    end
  endtask

  task automatic test_reset_mid_op();
    p_valid = 1'b1; p_addr = 5'd9; p_data = 32'hCAFE0009; p_pc = 32'h5000;
    m_valid = 1'b1; m_addr = 5'd3; m_data = 32'h33; m_pc = 32'h5004;
    #1;
    n_checks++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_p_ready: got %b want 1", p_ready); end
    tick();
    p_valid = 1'b0;
    reset_n = 1'b0;
    n_checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd9 || starve_cnt !== 3'd1) begin
      n_fail++; $display("FAIL rmid_inflight: got we=%b a3=%0d cnt=%0d want 1/9/1", grf_we, grf_a3, starve_cnt);
    end
    #1;
    n_checks++; if (m_ready !== 1'b0 || p_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ready: got p=%b m=%b want 0/0", p_ready, m_ready);
    end
    tick();
    n_checks++; if (grf_we !== 1'b0 || grf_a3 !== 5'd0 || grf_wd3 !== 32'd0 || grf_pc !== 32'd0) begin
      n_fail++; $display("FAIL rmid_regs: got we=%b a3=%0d wd3=%h pc=%h want zeros", grf_we, grf_a3, grf_wd3, grf_pc);
    end
    n_checks++; if (starve_cnt !== 3'd0) begin n_fail++; $display("FAIL rmid_starve: got %0d want 0", starve_cnt); end
    reset_n = 1'b1;
    m_valid = 1'b0;
  endtask

  task automatic test_random();
    logic          exp_we;
    logic [AW-1:0] exp_a3;
    logic [DW-1:0] exp_wd3;
    logic [31:0]   exp_pc;
    int            exp_starve;
    int            m_wait;
    logic          gp, gm;
    logic [DW-1:0] exp_rf [32];
    logic [DW-1:0] dut_rf [32];
    reset_n = 1'b0; p_valid = 1'b0; m_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_we = 1'b0; exp_a3 = '0; exp_wd3 = '0; exp_pc = '0;
    exp_starve = 0; m_wait = 0;
    for (int r = 0; r < 32; r++) begin exp_rf[r] = '0; dut_rf[r] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!p_valid && $urandom_range(0, 99) < 65) begin
        p_valid = 1'b1; p_addr = AW'($urandom_range(0, 31)); p_data = $urandom(); p_pc = $urandom();
      end
      if (!m_valid && $urandom_range(0, 99) < 50) begin
        m_valid = 1'b1; m_addr = AW'($urandom_range(0, 31)); m_data = $urandom(); m_pc = $urandom();
      end
      #1;
      gm = m_valid && (exp_starve == SMAX || !p_valid);
      gp = p_valid && !gm;
      n_checks++; if (p_ready !== gp || m_ready !== gm) begin
        n_fail++; $display("FAIL rnd_grant@%0d: got p=%b m=%b want p=%b m=%b", cyc, p_ready, m_ready, gp, gm);
      end
      if (m_valid) begin
        n_checks++; if (m_wait > SMAX) begin n_fail++; $display("FAIL rnd_mwait@%0d: got %0d want <=%0d", cyc, m_wait, SMAX); end
      end
      if (gp || gm) begin
        exp_a3  = gp ? p_addr : m_addr;
        exp_wd3 = gp ? p_data : m_data;
        exp_pc  = gp ? p_pc : m_pc;
        exp_we  = (exp_a3 != 0);
        if (exp_we) exp_rf[exp_a3] = exp_wd3;
      end else begin
        exp_we = 1'b0;
      end
      if (m_valid && !gm) begin
        exp_starve = (exp_starve + 1 > SMAX) ? SMAX : exp_starve + 1;
        m_wait++;
      end else begin
        exp_starve = 0;
        m_wait = 0;
      end
      tick();
      n_checks++; if (grf_we !== exp_we || grf_a3 !== exp_a3 || grf_wd3 !== exp_wd3 || grf_pc !== exp_pc) begin
        n_fail++; $display("FAIL rnd_out@%0d: got we=%b a3=%0d wd3=%h pc=%h want %b/%0d/%h/%h",
                           cyc, grf_we, grf_a3, grf_wd3, grf_pc, exp_we, exp_a3, exp_wd3, exp_pc);
      end
      n_checks++; if (starve_cnt !== 3'(exp_starve)) begin
        n_fail++; $display("FAIL rnd_starve@%0d: got %0d want %0d", cyc, starve_cnt, exp_starve);
      end
      if (grf_we === 1'b1) dut_rf[grf_a3] = grf_wd3;
      if (gp) p_valid = 1'b0;
      if (gm) m_valid = 1'b0;
    end
    for (int r = 1; r < 32; r++) begin
      n_checks++; if (dut_rf[r] !== exp_rf[r]) begin
        n_fail++; $display("FAIL rnd_rf$%0d: got %h want %h", r, dut_rf[r], exp_rf[r]);
      end
    end
    p_valid = 1'b0; m_valid = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_p_only();
    test_zero_drop();
    test_starvation();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
